// File: rtl/frontend_stall_stage.sv
// Load-use hazard responder: PC, IF/ID and ID/EX control registers that honour hold,
// bubble and branch-flush requests, plus saturating stall statistics and a stall watchdog.
module frontend_stall_stage #(
    parameter int ADDR_W    = 32,
    parameter int CTRL_W    = 9,
    parameter int CNT_W     = 16,
    parameter int MAX_STALL = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              pc_stall_i,
    input  logic              ifid_stall_i,
    input  logic              idex_ctrl_en_i,
    input  logic              flush_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    input  logic [ADDR_W-1:0] instr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] ifid_pc4_o,
    output logic [ADDR_W-1:0] ifid_instr_o,
    output logic [CTRL_W-1:0] idex_ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  bubble_cnt_o,
    output logic              stall_err_o
);

    // Run counter only needs to reach MAX_STALL+1, where it saturates.
    localparam int RUN_W = (MAX_STALL + 2 > 2) ? $clog2(MAX_STALL + 2) : 1;
    localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(MAX_STALL + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_STALL);

    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_ifid_pc4;
    logic [ADDR_W-1:0] r_ifid_instr;
    logic [CTRL_W-1:0] r_idex_ctrl;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic [RUN_W-1:0]  r_run;
    logic              r_stall_err;

    logic [ADDR_W-1:0] w_pc_plus4;
    logic [RUN_W-1:0]  w_run_inc;

    // Natural truncation gives the required modulo-2^ADDR_W wrap.
    assign w_pc_plus4 = r_pc + ADDR_W'(4);
    assign w_run_inc  = (r_run == RUN_SAT) ? r_run : r_run + RUN_W'(1);

    // NOTE: state uses non-blocking assignments and a reset sampled on the clock edge,
    // so a reset during a hold or flush simply overwrites whatever was pending.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_pc         <= '0;
            r_ifid_pc4   <= '0;
            r_ifid_instr <= '0;
            r_idex_ctrl  <= '0;
        end else begin
            if (!pc_stall_i) begin
                r_pc <= flush_i ? branch_target_i : w_pc_plus4;
            end

            if (!ifid_stall_i) begin
                if (flush_i) begin
                    r_ifid_pc4   <= '0;
                    r_ifid_instr <= '0;
                end else begin
                    r_ifid_pc4   <= w_pc_plus4;
                    r_ifid_instr <= instr_i;
                end
            end

            r_idex_ctrl <= idex_ctrl_en_i ? ctrl_i : '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_stall_cnt  <= '0;
            r_bubble_cnt <= '0;
        end else begin
            if (pc_stall_i && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
            if (!idex_ctrl_en_i && (r_bubble_cnt != '1)) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
        end
    end

    // Watchdog trips on the hold cycle that pushes the run past MAX_STALL; sticky.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_run       <= '0;
            r_stall_err <= 1'b0;
        end else if (pc_stall_i) begin
            r_run <= w_run_inc;
            if (w_run_inc > RUN_LIMIT) begin
                r_stall_err <= 1'b1;
            end
        end else begin
            r_run <= '0;
        end
    end

    assign pc_o         = r_pc;
    assign ifid_pc4_o   = r_ifid_pc4;
    assign ifid_instr_o = r_ifid_instr;
    assign idex_ctrl_o  = r_idex_ctrl;
    assign stall_cnt_o  = r_stall_cnt;
    assign bubble_cnt_o = r_bubble_cnt;
    assign stall_err_o  = r_stall_err;

endmodule
